// File: rtl/lift_in_cond_if.sv
// rtl/lift_in_cond_if.sv - signal bundle between the raw input lines and the lift controller
//
// Ports carried:
//   raw        [N-1:0]  unsynchronised sensor/button lines
//   ack                 call-acknowledge from the controller (its y1)
//   x          [N-1:0]  conditioned levels to the controller
//   chg                 one-cycle pulse when x changes
//   glitch_cnt [7:0]    saturating count of cycles with aborted debounces
// Modports:
//   master  drives raw/ack, observes the conditioned outputs
//   slave   the conditioning stage itself

interface lift_in_cond_if #(
    parameter int N = 14
);
    logic [N-1:0] raw;
    logic         ack;
    logic [N-1:0] x;
    logic         chg;
    logic [7:0]   glitch_cnt;

    modport master (
        output raw,
        output ack,
        input  x,
        input  chg,
        input  glitch_cnt
    );

    modport slave (
        input  raw,
        input  ack,
        output x,
        output chg,
        output glitch_cnt
    );
endinterface

// File: rtl/lift_in_cond.sv
// rtl/lift_in_cond.sv - synchronise, debounce and register the lift controller inputs
//
// Ports:
//   clk              single clock, all state on posedge
//   rst              asynchronous active-low reset
//   io (slave)       raw/ack in, x/chg/glitch_cnt out (see lift_in_cond_if)
// Parameters:
//   N                number of conditioned lines, bit i drives controller input x(i+1)
//   DB_CYCLES        synchronised cycles a new level must hold before acceptance (1..15)
// Optional feature:
//   LIFT_CALL_LATCH_EN  when defined, x[0] (call button) is latched until ack

module lift_in_cond #(
    parameter int N         = 14,
    parameter int DB_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    lift_in_cond_if.slave io
);

    localparam logic [3:0] CNT_LAST = 4'(DB_CYCLES - 1);

    logic [N-1:0]      s1;
    logic [N-1:0]      s2;
    logic [N-1:0]      deb;
    logic [N-1:0]      deb_nxt;
    logic [N-1:0][3:0] cnt;
    logic [N-1:0][3:0] cnt_nxt;
    logic [N-1:0]      abort;
    logic [N-1:0]      x_q;
    logic [N-1:0]      x_nxt;
    logic              chg_q;
    logic [7:0]        gc_q;
    logic [7:0]        gc_nxt;

    // Two-flop synchroniser on every raw line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= io.raw;
            s2 <= s1;
        end
    end

    // Per-bit debounce: a differing s2 must be seen DB_CYCLES times in a row.
    // Returning to the current level part way through is an abort.
    always_comb begin
        deb_nxt = deb;
        cnt_nxt = cnt;
        abort   = '0;
        for (int i = 0; i < N; i++) begin
            if (s2[i] == deb[i]) begin
                if (cnt[i] != 4'd0) begin
                    cnt_nxt[i] = 4'd0;
                    abort[i]   = 1'b1;
                end
            end else if (cnt[i] == CNT_LAST) begin
                deb_nxt[i] = s2[i];
                cnt_nxt[i] = 4'd0;
            end else begin
                cnt_nxt[i] = cnt[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb <= '0;
            cnt <= '0;
        end else begin
            deb <= deb_nxt;
            cnt <= cnt_nxt;
        end
    end

    // x is one register behind deb so a level accepted at edge DB_CYCLES+1
    // reaches the controller at edge DB_CYCLES+2.
`ifdef LIFT_CALL_LATCH_EN
    // x_q[0] is the call latch itself. deb0_q remembers the previous deb[0]
    // so a rising edge of the debounced call button can be detected; a set
    // in the same cycle as ack wins.
    logic deb0_q;
    logic call_set;

    assign call_set = deb[0] & ~deb0_q;

    always_comb begin
        x_nxt    = deb;
        x_nxt[0] = call_set | (x_q[0] & ~io.ack);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb0_q <= 1'b0;
        end else begin
            deb0_q <= deb[0];
        end
    end
`else
    logic unused_ack;

    assign unused_ack = io.ack;
    assign x_nxt      = deb;
`endif

    // Any number of aborts in one cycle counts once; saturate at 255.
    always_comb begin
        gc_nxt = gc_q;
        if ((|abort) && (gc_q != 8'hFF)) begin
            gc_nxt = gc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q   <= '0;
            chg_q <= 1'b0;
            gc_q  <= '0;
        end else begin
            x_q   <= x_nxt;
            chg_q <= (x_nxt != x_q);
            gc_q  <= gc_nxt;
        end
    end

    assign io.x          = x_q;
    assign io.chg        = chg_q;
    assign io.glitch_cnt = gc_q;

endmodule

// File: tb/tb_lift_in_cond.sv
// tb/tb_lift_in_cond.sv - self-checking bench for lift_in_cond

module tb_lift_in_cond;

    localparam int N  = 14;
    localparam int DB = 4;

    logic clk;
    logic rst;

    lift_in_cond_if #(.N(N)) bus ();

    lift_in_cond #(.N(N), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each line needs DB consecutive synchronised samples that differ from
    // its accepted level; the output register shows the accepted level one
    // cycle later.
    logic [N-1:0] m_s1, m_s2, m_deb, m_x, m_prev_deb;
    int           m_streak [N];
    logic         m_chg;
    int           m_gc;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_x = '0; m_prev_deb = '0;
        m_chg = 1'b0; m_gc = 0;
        for (int i = 0; i < N; i++) m_streak[i] = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] rw, input logic a);
        logic [N-1:0] seen;
        logic [N-1:0] xn;
        bit           any_abort;
        seen      = m_deb;
        any_abort = 0;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_streak[i] = m_streak[i] + 1;
                if (m_streak[i] >= DB) begin
                    m_deb[i]    = m_s2[i];
                    m_streak[i] = 0;
                end
            end else begin
                if (m_streak[i] > 0) any_abort = 1;
                m_streak[i] = 0;
            end
        end
        xn = seen;
`ifdef LIFT_CALL_LATCH_EN
        if (seen[0] && !m_prev_deb[0]) xn[0] = 1'b1;
        else if (a)                    xn[0] = 1'b0;
        else                           xn[0] = m_x[0];
`endif
        m_prev_deb = seen;
        m_chg = (xn != m_x);
        m_x   = xn;
        if (any_abort && m_gc < 255) m_gc = m_gc + 1;
        m_s2 = m_s1;
        m_s1 = rw;
    endtask

    // One clock: drive after negedge, sample 1 time unit after posedge.
    task automatic step(input logic r, input logic [N-1:0] rw, input logic a);
        @(negedge clk);
        rst     = r;
        bus.raw = rw;
        bus.ack = a;
        @(posedge clk);
        if (!r) model_reset();
        else    model_edge(rw, a);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         r;
        logic [N-1:0] raw;
        logic         a;
        logic [N-1:0] ex;
        logic         ec;
        int           eg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic [N-1:0] rw,
                       input logic [N-1:0] ex, input logic ec, input int eg);
        vec_t v;
        v.r = r; v.raw = rw; v.a = 1'b0; v.ex = ex; v.ec = ec; v.eg = eg;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    initial begin
        logic [N-1:0] xs [32];
        logic         cs [32];
        bit           quiet;
        bit           seen3;
        logic [N-1:0] rnd_raw;
        logic         rnd_rst;
        logic         rnd_ack;

        rst     = 1'b0;
        bus.raw = '0;
        bus.ack = 1'b0;
        model_reset();

        // Reset with raw all ones, release, then bit 5 falls and rises again.
        add(2, 1'b0, 14'h3FFF, 14'h0000, 1'b0, 0);
        add(6, 1'b1, 14'h3FFF, 14'h0000, 1'b0, 0);
        add(1, 1'b1, 14'h3FFF, 14'h3FFF, 1'b1, 0);
        add(1, 1'b1, 14'h3FFF, 14'h3FFF, 1'b0, 0);
        add(6, 1'b1, 14'h3FDF, 14'h3FFF, 1'b0, 0);
        add(1, 1'b1, 14'h3FDF, 14'h3FDF, 1'b1, 0);
        add(1, 1'b1, 14'h3FDF, 14'h3FDF, 1'b0, 0);
        add(6, 1'b1, 14'h3FFF, 14'h3FDF, 1'b0, 0);
        add(1, 1'b1, 14'h3FFF, 14'h3FFF, 1'b1, 0);
        add(2, 1'b1, 14'h3FFF, 14'h3FFF, 1'b0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].raw, tbl[i].a);
            chk($sformatf("vec%0d_x", i),   32'(bus.x),          32'(tbl[i].ex));
            chk($sformatf("vec%0d_chg", i), 32'(bus.chg),        32'(tbl[i].ec));
            chk($sformatf("vec%0d_gc", i),  32'(bus.glitch_cnt), 32'(tbl[i].eg));
        end

        // Glitches: 2-cycle, simultaneous 2-cycle, 1-cycle, 3-cycle (all rejected).
        do_reset();
        quiet = 1;
        for (int k = 0; k < 2; k++) begin step(1'b1, 14'h0008, 1'b0); if (bus.x != 0 || bus.chg) quiet = 0; end
        for (int k = 0; k < 8; k++) begin step(1'b1, 14'h0000, 1'b0); if (bus.x != 0 || bus.chg) quiet = 0; end
        chk("glitch2_gc", 32'(bus.glitch_cnt), 32'd1);
        for (int k = 0; k < 2; k++) begin step(1'b1, 14'h0088, 1'b0); if (bus.x != 0 || bus.chg) quiet = 0; end
        for (int k = 0; k < 8; k++) begin step(1'b1, 14'h0000, 1'b0); if (bus.x != 0 || bus.chg) quiet = 0; end
        chk("glitch_simul_gc", 32'(bus.glitch_cnt), 32'd2);
        step(1'b1, 14'h0008, 1'b0);
        for (int k = 0; k < 8; k++) begin step(1'b1, 14'h0000, 1'b0); if (bus.x != 0 || bus.chg) quiet = 0; end
        chk("glitch1_gc", 32'(bus.glitch_cnt), 32'd3);
        for (int k = 0; k < DB - 1; k++) begin step(1'b1, 14'h0008, 1'b0); if (bus.x != 0 || bus.chg) quiet = 0; end
        for (int k = 0; k < 8; k++) begin step(1'b1, 14'h0000, 1'b0); if (bus.x != 0 || bus.chg) quiet = 0; end
        chk("glitch3_gc", 32'(bus.glitch_cnt), 32'd4);
        chk("glitch_x_quiet", 32'(quiet), 32'd1);

        // A pulse of exactly DB synchronised cycles is accepted, no abort.
        seen3 = 0;
        for (int k = 0; k < DB; k++) begin step(1'b1, 14'h0008, 1'b0); if (bus.x[3]) seen3 = 1; end
        for (int k = 0; k < 12; k++) begin step(1'b1, 14'h0000, 1'b0); if (bus.x[3]) seen3 = 1; end
        chk("pulse_db_seen", 32'(seen3), 32'd1);
        chk("pulse_db_x_back", 32'(bus.x), 32'd0);
        chk("pulse_db_gc", 32'(bus.glitch_cnt), 32'd4);

        // Saturation.
        for (int g = 0; g < 300; g++) begin
            step(1'b1, 14'h0010, 1'b0);
            step(1'b1, 14'h0010, 1'b0);
            for (int k = 0; k < 4; k++) step(1'b1, 14'h0000, 1'b0);
        end
        chk("sat_gc", 32'(bus.glitch_cnt), 32'd255);
        step(1'b1, 14'h0010, 1'b0);
        step(1'b1, 14'h0010, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b1, 14'h0000, 1'b0);
        chk("sat_hold_gc", 32'(bus.glitch_cnt), 32'd255);

        // Call button: raw[0] high 8 cycles then low; xs[e] is x after edge e.
        do_reset();
        for (int e = 0; e < 20; e++) begin
            step(1'b1, (e < 8) ? 14'h0001 : 14'h0000, 1'b0);
            xs[e] = bus.x;
            cs[e] = bus.chg;
        end
        chk("call_rise_e5", 32'(xs[5][0]), 32'd0);
        chk("call_rise_e6", 32'(xs[6][0]), 32'd1);
        chk("call_rise_chg", 32'(cs[6]), 32'd1);
        chk("call_e13", 32'(xs[13][0]), 32'd1);
`ifdef LIFT_CALL_LATCH_EN
        chk("call_latched_e14", 32'(xs[14][0]), 32'd1);
        chk("call_latched_e19", 32'(xs[19][0]), 32'd1);
        step(1'b1, 14'h0000, 1'b1);
        chk("call_ack_x", 32'(bus.x[0]), 32'd0);
        chk("call_ack_chg", 32'(bus.chg), 32'd1);
        step(1'b1, 14'h0000, 1'b0);
        chk("call_after_x", 32'(bus.x[0]), 32'd0);
        chk("call_after_chg", 32'(bus.chg), 32'd0);
`else
        chk("call_fall_e14", 32'(xs[14][0]), 32'd0);
        chk("call_fall_chg", 32'(cs[14]), 32'd1);
        step(1'b1, 14'h0000, 1'b1);
        chk("call_ack_ignored_x", 32'(bus.x), 32'd0);
        chk("call_ack_ignored_chg", 32'(bus.chg), 32'd0);
`endif

        // Reset mid-count on rising raw[2].
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 14'h0004, 1'b0);
        step(1'b0, 14'h0004, 1'b0);
        chk("midrst_x", 32'(bus.x), 32'd0);
        step(1'b0, 14'h0004, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b1, 14'h0004, 1'b0);
        chk("midrst_e5_x", 32'(bus.x), 32'd0);
        step(1'b1, 14'h0004, 1'b0);
        chk("midrst_e6_x", 32'(bus.x), 32'h0004);
        chk("midrst_e6_chg", 32'(bus.chg), 32'd1);

        // Randomised run against the model.
        do_reset();
        rnd_raw = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) rnd_raw[i] = ~rnd_raw[i];
            rnd_ack = ($urandom_range(0, 7) == 0);
            rnd_rst = ($urandom_range(0, 499) != 0);
            step(rnd_rst, rnd_raw, rnd_ack);
            chk($sformatf("rnd%0d_x", c),   32'(bus.x),          32'(m_x));
            chk($sformatf("rnd%0d_chg", c), 32'(bus.chg),        32'(m_chg));
            chk($sformatf("rnd%0d_gc", c),  32'(bus.glitch_cnt), 32'(m_gc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
